// File: rtl/timing_stats_if.sv
// Bus interface for timing_stats: the sensor-side inputs from the timing
// manager and the statistics read back by the PS register block.
// The slave modport is the statistics stage; the master modport is its driver.
interface timing_stats_if #(
  parameter int WIDTH = 16
);
  logic             en;
  logic             trigger;
  logic             done;
  logic [WIDTH-1:0] time_in;
  logic             clear_stats;
  logic [WIDTH-1:0] last_time;
  logic [WIDTH-1:0] min_time;
  logic [WIDTH-1:0] max_time;
  logic [WIDTH-1:0] avg_time;
  logic             avg_valid;
  logic [15:0]      sample_count;
  logic [15:0]      overrun_count;
  logic             overrun;
  logic             busy;

  modport slave (
    input  en, trigger, done, time_in, clear_stats,
    output last_time, min_time, max_time, avg_time, avg_valid,
           sample_count, overrun_count, overrun, busy
  );

  modport master (
    output en, trigger, done, time_in, clear_stats,
    input  last_time, min_time, max_time, avg_time, avg_valid,
           sample_count, overrun_count, overrun, busy
  );
endinterface

// File: rtl/timing_stats.sv
// Per-sensor acquisition-time statistics: last/min/max/windowed average,
// saturating sample and overrun counters, and an IDLE/WAIT/DONE tracker
// that flags triggers arriving before the sensor finished.
// Optional macro TIMING_STATS_AVG_EN enables the windowed-average
// accumulator; without it avg_time and avg_valid are tied to zero.
module timing_stats #(
  parameter int WIDTH    = 16,
  parameter int AVG_LOG2 = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  timing_stats_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             done_q;
  logic             done_pe_q;
  logic             strobe;
  logic             overrun_evt;
  logic [WIDTH-1:0] sample;
  logic [WIDTH-1:0] last_q;
  logic [WIDTH-1:0] min_q;
  logic [WIDTH-1:0] max_q;
  logic [15:0]      count_q;
  logic [15:0]      ovr_count_q;
  logic             ovr_q;

  // AVG_LOG2 outside 0..8 is not supported; such builds get an empty marker block
  if (AVG_LOG2 < 0 || AVG_LOG2 > 8) begin : g_illegal_avg_log2
  end

  assign sample = bus.time_in;
  assign strobe = done_pe_q & bus.en;

  // Done edge detect; done_q tracks even while disabled so re-enable sees no false edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q    <= 1'b0;
      done_pe_q <= 1'b0;
    end else begin
      done_q    <= bus.done;
      done_pe_q <= bus.done & ~done_q & bus.en;
    end
  end

  // Tracker state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and overrun detection; a strobe coinciding with a trigger re-arms without overrun
  always_comb begin
    state_d     = state_q;
    overrun_evt = 1'b0;
    if (!bus.en) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (bus.trigger) state_d = S_WAIT;
        S_WAIT: begin
          if (strobe) begin
            state_d = bus.trigger ? S_WAIT : S_DONE;
          end else if (bus.trigger) begin
            overrun_evt = 1'b1;
          end
        end
        S_DONE: if (bus.trigger) state_d = S_WAIT;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Sample and overrun statistics; clear wins over a coincident strobe or overrun
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q      <= '0;
      min_q       <= '1;
      max_q       <= '0;
      count_q     <= '0;
      ovr_count_q <= '0;
      ovr_q       <= 1'b0;
    end else if (bus.clear_stats) begin
      last_q      <= '0;
      min_q       <= '1;
      max_q       <= '0;
      count_q     <= '0;
      ovr_count_q <= '0;
      ovr_q       <= 1'b0;
    end else begin
      if (strobe) begin
        last_q <= sample;
        if (sample < min_q) min_q <= sample;
        if (sample > max_q) max_q <= sample;
        if (count_q != 16'hFFFF) count_q <= count_q + 16'd1;
      end
      if (overrun_evt) begin
        ovr_q <= 1'b1;
        if (ovr_count_q != 16'hFFFF) ovr_count_q <= ovr_count_q + 16'd1;
      end
    end
  end

`ifdef TIMING_STATS_AVG_EN
  logic [WIDTH-1:0] avg_q;
  logic             avg_valid_q;

  if (AVG_LOG2 == 0) begin : g_avg_direct
    // Single-sample window: the average is simply the latest sample
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        avg_q       <= '0;
        avg_valid_q <= 1'b0;
      end else if (bus.clear_stats) begin
        avg_q       <= '0;
        avg_valid_q <= 1'b0;
      end else if (strobe) begin
        avg_q       <= sample;
        avg_valid_q <= 1'b1;
      end
    end
  end else begin : g_avg_window
    logic [WIDTH+AVG_LOG2-1:0] sum_q;
    logic [WIDTH+AVG_LOG2-1:0] sum_next;
    logic [AVG_LOG2-1:0]       win_q;

    assign sum_next = sum_q + {{AVG_LOG2{1'b0}}, sample};

    // Accumulate a window of 2^AVG_LOG2 samples, then publish the truncated mean
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sum_q       <= '0;
        win_q       <= '0;
        avg_q       <= '0;
        avg_valid_q <= 1'b0;
      end else if (bus.clear_stats) begin
        sum_q       <= '0;
        win_q       <= '0;
        avg_q       <= '0;
        avg_valid_q <= 1'b0;
      end else if (strobe) begin
        if (win_q == '1) begin
          avg_q       <= sum_next[WIDTH+AVG_LOG2-1:AVG_LOG2];
          sum_q       <= '0;
          win_q       <= '0;
          avg_valid_q <= 1'b1;
        end else begin
          sum_q <= sum_next;
          win_q <= win_q + 1'b1;
        end
      end
    end
  end

  assign bus.avg_time  = avg_q;
  assign bus.avg_valid = avg_valid_q;
`else
  assign bus.avg_time  = '0;
  assign bus.avg_valid = 1'b0;
`endif

  assign bus.last_time     = last_q;
  assign bus.min_time      = min_q;
  assign bus.max_time      = max_q;
  assign bus.sample_count  = count_q;
  assign bus.overrun_count = ovr_count_q;
  assign bus.overrun       = ovr_q;
  assign bus.busy          = (state_q == S_WAIT);

endmodule

// File: tb/tb_timing_stats.sv
// Directed testbench for timing_stats (WIDTH=16, AVG_LOG2=2).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_timing_stats;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  timing_stats_if #(.WIDTH(16)) bus ();

  timing_stats #(.WIDTH(16), .AVG_LOG2(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_trigger();
    bus.trigger = 1'b1;
    tick(1);
    bus.trigger = 1'b0;
    tick(1);
  endtask

  // done rises with time_in; statistics visible two rising edges later
  task automatic do_sample(input logic [15:0] t);
    bus.time_in = t;
    bus.done    = 1'b1;
    tick(1);
    bus.done    = 1'b0;
    tick(1);
  endtask

  task automatic pulse_clear();
    bus.clear_stats = 1'b1;
    tick(1);
    bus.clear_stats = 1'b0;
  endtask

  task automatic test_reset();
    rst_n           = 1'b0;
    bus.en          = 1'b0;
    bus.trigger     = 1'b0;
    bus.done        = 1'b0;
    bus.time_in     = '0;
    bus.clear_stats = 1'b0;
    tick(2);
    checks++; if (bus.min_time !== 16'hFFFF) begin errors++; $display("[TB] FAIL reset_min: got %h want ffff", bus.min_time); end
    checks++; if (bus.max_time !== 16'h0 || bus.last_time !== 16'h0 || bus.avg_time !== 16'h0) begin errors++; $display("[TB] FAIL reset_max_last_avg: got %h %h %h want 0 0 0", bus.max_time, bus.last_time, bus.avg_time); end
    checks++; if ({bus.busy, bus.overrun, bus.avg_valid} !== 3'b000 || bus.sample_count !== 16'h0 || bus.overrun_count !== 16'h0) begin errors++; $display("[TB] FAIL reset_flags_counts: got %b %h %h want 000 0 0", {bus.busy, bus.overrun, bus.avg_valid}, bus.sample_count, bus.overrun_count); end
    rst_n  = 1'b1;
    bus.en = 1'b1;
    tick(1);
  endtask

  task automatic test_basic_capture();
    pulse_trigger();
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy_wait: got %b want 1", bus.busy); end
    do_sample(16'd100);
    checks++; if (bus.last_time !== 16'd100 || bus.min_time !== 16'd100 || bus.max_time !== 16'd100) begin errors++; $display("[TB] FAIL basic_lmm: got %0d %0d %0d want 100 100 100", bus.last_time, bus.min_time, bus.max_time); end
    checks++; if (bus.sample_count !== 16'd1 || bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_count_busy: got %0d %b want 1 0", bus.sample_count, bus.busy); end
  endtask

  task automatic test_min_max_avg();
    logic [15:0] exp_avg1;
    logic [15:0] exp_avg2;
    logic        exp_valid;
`ifdef TIMING_STATS_AVG_EN
    exp_avg1  = 16'd125;
    exp_avg2  = 16'd10;
    exp_valid = 1'b1;
`else
    exp_avg1  = 16'd0;
    exp_avg2  = 16'd0;
    exp_valid = 1'b0;
`endif
    pulse_clear();
    tick(1);
    do_sample(16'd100);
    do_sample(16'd40);
    do_sample(16'd300);
    checks++; if (bus.avg_valid !== 1'b0) begin errors++; $display("[TB] FAIL avg_valid_early: got %b want 0", bus.avg_valid); end
    do_sample(16'd60);
    checks++; if (bus.min_time !== 16'd40 || bus.max_time !== 16'd300) begin errors++; $display("[TB] FAIL minmax: got %0d %0d want 40 300", bus.min_time, bus.max_time); end
    checks++; if (bus.avg_time !== exp_avg1 || bus.avg_valid !== exp_valid) begin errors++; $display("[TB] FAIL avg_window1: got %0d %b want %0d %b", bus.avg_time, bus.avg_valid, exp_avg1, exp_valid); end
    do_sample(16'd10);
    do_sample(16'd11);
    do_sample(16'd11);
    do_sample(16'd11);
    checks++; if (bus.avg_time !== exp_avg2 || bus.min_time !== 16'd10 || bus.sample_count !== 16'd8) begin errors++; $display("[TB] FAIL avg_window2: got %0d %0d %0d want %0d 10 8", bus.avg_time, bus.min_time, bus.sample_count, exp_avg2); end
  endtask

  task automatic test_overrun();
    pulse_clear();
    tick(1);
    pulse_trigger();
    pulse_trigger();
    checks++; if (bus.overrun !== 1'b1 || bus.overrun_count !== 16'd1 || bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL overrun_event: got %b %0d %b want 1 1 1", bus.overrun, bus.overrun_count, bus.busy); end
    do_sample(16'd7);
    checks++; if (bus.busy !== 1'b0 || bus.overrun !== 1'b1 || bus.last_time !== 16'd7) begin errors++; $display("[TB] FAIL overrun_then_done: got %b %b %0d want 0 1 7", bus.busy, bus.overrun, bus.last_time); end
  endtask

  task automatic test_coincidence();
    pulse_clear();
    tick(1);
    bus.time_in     = 16'd50;
    bus.done        = 1'b1;
    tick(1);
    bus.done        = 1'b0;
    bus.clear_stats = 1'b1;
    tick(1);
    bus.clear_stats = 1'b0;
    checks++; if (bus.sample_count !== 16'd0 || bus.min_time !== 16'hFFFF || bus.last_time !== 16'd0) begin errors++; $display("[TB] FAIL clear_vs_strobe: got %0d %h %0d want 0 ffff 0", bus.sample_count, bus.min_time, bus.last_time); end
    pulse_trigger();
    bus.time_in = 16'd33;
    bus.done    = 1'b1;
    tick(1);
    bus.done    = 1'b0;
    bus.trigger = 1'b1;
    tick(1);
    bus.trigger = 1'b0;
    checks++; if (bus.overrun !== 1'b0 || bus.overrun_count !== 16'd0 || bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL trig_strobe_rearm: got %b %0d %b want 0 0 1", bus.overrun, bus.overrun_count, bus.busy); end
    checks++; if (bus.sample_count !== 16'd1 || bus.last_time !== 16'd33) begin errors++; $display("[TB] FAIL trig_strobe_sample: got %0d %0d want 1 33", bus.sample_count, bus.last_time); end
  endtask

  task automatic test_enable();
    bus.en = 1'b0;
    tick(1);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL disable_idle: got %b want 0", bus.busy); end
    for (int i = 0; i < 3; i++) begin
      bus.time_in = 16'd900 + 16'(i);
      pulse_trigger();
      do_sample(16'd5);
    end
    bus.done = 1'b1;
    tick(2);
    bus.en = 1'b1;
    tick(3);
    bus.done = 1'b0;
    tick(1);
    checks++; if (bus.sample_count !== 16'd1 || bus.last_time !== 16'd33 || bus.min_time !== 16'd33 || bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL disabled_hold: got %0d %0d %0d %b want 1 33 33 0", bus.sample_count, bus.last_time, bus.min_time, bus.busy); end
  endtask

  task automatic test_saturation();
    pulse_clear();
    tick(1);
    bus.trigger = 1'b1;
    tick(65540);
    bus.trigger = 1'b0;
    tick(1);
    checks++; if (bus.overrun_count !== 16'hFFFF || bus.overrun !== 1'b1 || bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL overrun_saturate: got %h %b %b want ffff 1 1", bus.overrun_count, bus.overrun, bus.busy); end
  endtask

  task automatic test_reset_mid();
    do_sample(16'd77);
    pulse_trigger();
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.overrun !== 1'b0 || bus.overrun_count !== 16'h0 || bus.sample_count !== 16'h0) begin errors++; $display("[TB] FAIL async_reset_flags: got %b %b %h %h want 0 0 0 0", bus.busy, bus.overrun, bus.overrun_count, bus.sample_count); end
    checks++; if (bus.min_time !== 16'hFFFF || bus.max_time !== 16'h0 || bus.avg_valid !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_stats: got %h %h %b want ffff 0 0", bus.min_time, bus.max_time, bus.avg_valid); end
    tick(1);
    rst_n = 1'b1;
    tick(1);
    pulse_trigger();
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_idle_to_wait: got %b want 1", bus.busy); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic_capture();
    test_min_max_avg();
    test_overrun();
    test_coincidence();
    test_enable();
    test_saturation();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
